// File: rtl/cronometro_pkg.sv
// cronometro_pkg: shared state encoding and default tick divider for the stopwatch chain.
// Also imported by the digit counters.
package cronometro_pkg;
   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] RUN   = 2'b01;
   localparam logic [1:0] LAP   = 2'b10;
   localparam logic [1:0] PAUSE = 2'b11;
   localparam int unsigned DIV_DEFAULT = 500000;
endpackage

// File: rtl/detector_flanco.sv
// detector_flanco: rising-edge detector for one debounced, clk-synchronous button.
// Ports: clk, reset (sync, active-low), btn (level in), flanco (combinational edge out).
// prev resets to 1, so a button held through reset release gives no edge.
module detector_flanco (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic flanco
);
   logic prev;
   always_ff @(posedge clk)
      prev <= !reset ? 1'b1 : btn;
   assign flanco = btn & ~prev;
endmodule

// File: rtl/control_cronometro.sv
// control_cronometro: run/lap/pause sequencer producing the centisecond tick and clear pulse.
// Ports: clk, reset (sync, active-low), btn_ss/btn_lap/btn_clr (debounced levels),
//        cnt_en (tick), cnt_clr (clear pulse), disp_hold (LAP freeze), running, state.
module control_cronometro
   import cronometro_pkg::*;
#(
   parameter int unsigned DIV = DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic       running,
   output logic [1:0] state
);
   localparam int W = $clog2(DIV);
   logic         ss_e, lap_e, clr_e, clr_pulse, idle_or_pause;
   logic [1:0]   nxt;
   logic [W-1:0] pre;
   logic         wrap;

   detector_flanco u_ss  (.clk(clk), .reset(reset), .btn(btn_ss),  .flanco(ss_e));
   detector_flanco u_lap (.clk(clk), .reset(reset), .btn(btn_lap), .flanco(lap_e));
   detector_flanco u_clr (.clk(clk), .reset(reset), .btn(btn_clr), .flanco(clr_e));

   // ss outranks lap and clr; a losing edge is simply dropped
   always_comb begin
      idle_or_pause = (state == IDLE) || (state == PAUSE);
      clr_pulse     = clr_e && !ss_e && idle_or_pause;
      nxt = ss_e                     ? (idle_or_pause ? RUN : PAUSE) :
            lap_e && state == RUN    ? LAP :
            lap_e && state == LAP    ? RUN :
            clr_pulse                ? IDLE : state;
   end

   // running mirrors state RUN/LAP, so it gates the prescaler using the current state
   assign wrap = running && (pre == W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         running   <= 1'b0;
         disp_hold <= 1'b0;
         cnt_en    <= 1'b0;
         cnt_clr   <= 1'b0;
         pre       <= '0;
      end else begin
         state     <= nxt;
         running   <= (nxt == RUN) || (nxt == LAP);
         disp_hold <= nxt == LAP;
         cnt_en    <= wrap;
         cnt_clr   <= clr_pulse;
         pre       <= clr_pulse ? '0 : wrap ? '0 : running ? pre + 1'b1 : pre;
      end
   end
endmodule

// File: tb/tb_control_cronometro.sv
// tb_control_cronometro: directed self-checking bench for control_cronometro with DIV=4.
module tb_control_cronometro;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
   logic       cnt_en, cnt_clr, disp_hold, running;
   logic [1:0] state;
   int checks = 0, errors = 0;

   control_cronometro #(.DIV(4)) dut (
      .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
      .cnt_en(cnt_en), .cnt_clr(cnt_clr), .disp_hold(disp_hold), .running(running), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one-cycle press: the edge is sampled on the next clock edge
   task automatic press(input logic s, input logic l, input logic c);
      btn_ss = s; btn_lap = l; btn_clr = c;
      tick(1);
      btn_ss = 0; btn_lap = 0; btn_clr = 0;
   endtask

   initial begin
      tick(2);
      chk("rst_state", state, 0);
      chk("rst_running", running, 0);
      chk("rst_cnt_en", cnt_en, 0);
      chk("rst_cnt_clr", cnt_clr, 0);
      chk("rst_hold", disp_hold, 0);
      reset = 1; tick(1);

      press(1, 0, 0);
      chk("run_running", running, 1);
      chk("run_state", state, 1);
      tick(3); chk("tick4_pre", cnt_en, 0);
      tick(1); chk("tick4", cnt_en, 1);
      tick(3); chk("tick8_pre", cnt_en, 0);
      tick(1); chk("tick8", cnt_en, 1);
      tick(4); chk("tick12", cnt_en, 1);

      press(1, 0, 0); chk("pause_state", state, 3);
      press(0, 0, 1);
      chk("clr_pulse", cnt_clr, 1);
      chk("clr_idle", state, 0);
      tick(1); chk("clr_single", cnt_clr, 0);

      // phase preservation: 6 cycles of RUN, pause, resume
      press(1, 0, 0);
      tick(5);
      press(1, 0, 0);
      chk("ph_pause", state, 3);
      chk("ph_pause_run", running, 0);
      for (int i = 0; i < 9; i++) begin
         tick(1); chk("pause_no_tick", cnt_en, 0);
      end
      press(1, 0, 0);
      chk("ph_resume", state, 1);
      tick(1); chk("ph_tick_pre", cnt_en, 0);
      tick(1); chk("ph_tick", cnt_en, 1);

      press(0, 1, 0);
      chk("lap_state", state, 2);
      chk("lap_hold", disp_hold, 1);
      chk("lap_running", running, 1);
      tick(2); chk("lap_tick_pre", cnt_en, 0);
      tick(1); chk("lap_tick1", cnt_en, 1);
      tick(3); chk("lap_tick_pre2", cnt_en, 0);
      tick(1); chk("lap_tick2", cnt_en, 1);
      press(0, 1, 0);
      chk("lap2_state", state, 1);
      chk("lap2_hold", disp_hold, 0);

      press(0, 0, 1);
      chk("clr_run_pulse", cnt_clr, 0);
      chk("clr_run_state", state, 1);

      press(1, 1, 0);
      chk("sslap_state", state, 3);
      chk("sslap_hold", disp_hold, 0);

      press(0, 0, 1);
      chk("clr2_pulse", cnt_clr, 1);
      chk("clr2_state", state, 0);
      tick(1); chk("clr2_single", cnt_clr, 0);
      press(1, 0, 0);
      tick(3); chk("fresh_pre", cnt_en, 0);
      tick(1); chk("fresh_tick", cnt_en, 1);

      btn_ss = 1;
      tick(1); chk("hold_first", state, 3);
      tick(19); chk("hold_stay", state, 3);
      btn_ss = 0; tick(1); chk("hold_release", state, 3);

      reset = 0; btn_ss = 1; tick(2);
      reset = 1; tick(3);
      chk("held_rst_state", state, 0);
      btn_ss = 0; tick(1);

      press(1, 0, 0);
      press(0, 1, 0);
      chk("lap3_hold", disp_hold, 1);
      reset = 0; tick(1);
      chk("midrst_state", state, 0);
      chk("midrst_running", running, 0);
      chk("midrst_hold", disp_hold, 0);
      chk("midrst_cnt_en", cnt_en, 0);
      chk("midrst_cnt_clr", cnt_clr, 0);
      reset = 1; tick(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
